// File: rtl/debounced_cmd_frontend.sv
// Push-button front end: synchronise, debounce and edge-detect NUM_CMD buttons, then queue
// priority-encoded {code, key, data} commands in a show-ahead FIFO drained by valid/ready.
module debounced_cmd_frontend #(
    parameter int NUM_CMD         = 3,
    parameter int KEY_SIZE        = 2,
    parameter int DATA_SIZE       = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE            = 0,
    parameter int FIFO_DEPTH      = 4,
    parameter int CW              = $clog2(NUM_CMD + 1),
    parameter int CNTW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 async_nreset,
    input  logic [NUM_CMD-1:0]   btn,
    input  logic [KEY_SIZE-1:0]  key,
    input  logic [DATA_SIZE-1:0] data,
    input  logic                 cmd_ready,
    input  logic                 ovf_clear,
    output logic                 cmd_valid,
    output logic [CW-1:0]        cmd_code,
    output logic [KEY_SIZE-1:0]  cmd_key,
    output logic [DATA_SIZE-1:0] cmd_data,
    output logic [CNTW-1:0]      fifo_count,
    output logic                 overflow
);
    // The counter clears instead of reaching DEBOUNCE_CYCLES, so it only ever holds 0..D-1.
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic ACTIVE_LVL = (EDGE != 0);
    localparam logic [NUM_CMD-1:0] IDLE = {NUM_CMD{~ACTIVE_LVL}};

    typedef struct packed {
        logic [CW-1:0]        code;
        logic [KEY_SIZE-1:0]  key;
        logic [DATA_SIZE-1:0] data;
    } entry_t;

    logic [NUM_CMD-1:0] sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d, press;
    logic [DBW-1:0]     cnt_q [NUM_CMD];
    logic [DBW-1:0]     cnt_d [NUM_CMD];
    logic               evt_valid_q, evt_valid_d;
    logic [CW-1:0]      evt_code_q, evt_code_d;
    entry_t             mem_q [FIFO_DEPTH];
    entry_t             head;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]    count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               empty, full, do_pop, do_push;

    always_comb begin
        // NOTE: every signal written here gets a default before any branch; a path that leaves one unassigned infers a latch.
        sync1_d  = btn;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press    = '0;
        for (int i = 0; i < NUM_CMD; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                    press[i]    = (sync2_q[i] == ACTIVE_LVL);
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Lowest-index press wins; simultaneous presses on other channels are dropped silently.
    always_comb begin
        evt_valid_d = |press;
        evt_code_d  = '0;
        for (int i = NUM_CMD - 1; i >= 0; i--) begin
            if (press[i]) evt_code_d = CW'(i + 1);
        end
    end

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNTW'(FIFO_DEPTH));
        do_pop  = !empty && cmd_ready;
        do_push = evt_valid_q && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
        ovf_d = ovf_q;
        if (ovf_clear) ovf_d = 1'b0;
        if (evt_valid_q && full && !do_pop) ovf_d = 1'b1;
        head = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            sync1_q     <= IDLE;
            sync2_q     <= IDLE;
            stable_q    <= IDLE;
            for (int i = 0; i < NUM_CMD; i++) cnt_q[i] <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stable_q    <= stable_d;
            for (int i = 0; i < NUM_CMD; i++) cnt_q[i] <= cnt_d[i];
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: queue storage is deliberately not reset; entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {evt_code_q, key, data};
    end

    assign cmd_valid  = !empty;
    assign cmd_code   = empty ? '0 : head.code;
    assign cmd_key    = empty ? '0 : head.key;
    assign cmd_data   = empty ? '0 : head.data;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_debounced_cmd_frontend.sv
// Directed bench for debounced_cmd_frontend with D=4, FIFO_DEPTH=4, NUM_CMD=3, active-low buttons.
module tb_debounced_cmd_frontend;
    localparam int D = 4;

    logic       clk, async_nreset;
    logic [2:0] btn;
    logic [1:0] key;
    logic [3:0] data;
    logic       cmd_ready, ovf_clear;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [1:0] cmd_key;
    logic [3:0] cmd_data;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  btn;
        logic [1:0]  key;
        logic [3:0]  data;
        logic        ready;
        logic [12:0] exp_out;
    } vec_t;

    vec_t tbl [16];
    int   ov_ch   [5] = '{0, 1, 2, 0, 1};
    int   ov_cnt  [5] = '{1, 2, 3, 4, 4};
    int   ov_flag [5] = '{0, 0, 0, 0, 1};
    int   dr_code [4] = '{1, 2, 3, 1};
    int   dr2_code[4] = '{2, 3, 1, 2};
    int   dr2_data[4] = '{7, 8, 9, 11};

    debounced_cmd_frontend #(
        .NUM_CMD(3), .KEY_SIZE(2), .DATA_SIZE(4),
        .DEBOUNCE_CYCLES(D), .EDGE(0), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .async_nreset(async_nreset), .btn(btn), .key(key), .data(data),
        .cmd_ready(cmd_ready), .ovf_clear(ovf_clear), .cmd_valid(cmd_valid),
        .cmd_code(cmd_code), .cmd_key(cmd_key), .cmd_data(cmd_data),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    function automatic logic [12:0] out_vec();
        return {cmd_valid, cmd_code, cmd_key, cmd_data, fifo_count, overflow};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press channel ch long enough to enqueue, then release and let it settle.
    task automatic press(input int ch, input logic [3:0] dat);
        data    = dat;
        btn[ch] = 1'b0;
        repeat (8) tick();
        btn = 3'b111;
        repeat (8) tick();
    endtask

    // Edge index (0 = first edge after the call) at which cmd_valid is first seen, -1 on timeout.
    task automatic wait_valid(input int max_edges, output int edges);
        edges = -1;
        for (int k = 0; k < max_edges; k++) begin
            tick();
            if (cmd_valid === 1'b1) begin
                edges = k;
                return;
            end
        end
    endtask

    initial begin
        int   edges;
        int   peak;
        logic seen;

        for (int i = 0; i < 16; i++) begin
            tbl[i].btn     = (i < 8) ? 3'b101 : 3'b111;
            tbl[i].key     = 2'd2;
            tbl[i].data    = 4'hA;
            tbl[i].ready   = 1'b1;
            tbl[i].exp_out = (i == 6) ? {1'b1, 2'd2, 2'd2, 4'hA, 3'd1, 1'b0} : 13'd0;
        end

        async_nreset = 1'b1; btn = 3'b111; key = '0; data = '0;
        cmd_ready = 1'b0; ovf_clear = 1'b0;

        // Reset
        #2 async_nreset = 1'b0;
        #1 check("reset_immediate", out_vec(), 0);
        #10 async_nreset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("reset_hold_%0d", i), out_vec(), 0);
        end

        // Single press on channel 1 and its release
        for (int i = 0; i < 16; i++) begin
            btn = tbl[i].btn; key = tbl[i].key; data = tbl[i].data; cmd_ready = tbl[i].ready;
            tick();
            check($sformatf("press_e%0d", i), out_vec(), tbl[i].exp_out);
        end

        // Bounce: 3-cycle low pulses never qualify
        seen = 1'b0;
        for (int p = 0; p < 10; p++) begin
            btn[0] = 1'b0;
            repeat (3) begin tick(); seen |= cmd_valid; end
            btn[0] = 1'b1;
            repeat (3) begin tick(); seen |= cmd_valid; end
        end
        check("bounce_no_cmd", seen, 0);
        btn[0] = 1'b0;
        wait_valid(20, edges);
        check("bounce_latency", edges, 6);
        check("bounce_code", cmd_code, 1);
        tick();
        check("bounce_popped", cmd_valid, 0);
        btn = 3'b111;
        seen = 1'b0;
        repeat (10) begin tick(); seen |= cmd_valid; end
        check("bounce_release", seen, 0);

        // Simultaneous press on channels 0 and 2
        cmd_ready = 1'b0;
        btn = 3'b010;
        peak = 0;
        repeat (16) begin
            tick();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        check("simul_peak", peak, 1);
        check("simul_code", cmd_code, 1);
        btn = 3'b111;
        repeat (8) tick();
        check("simul_count_after_release", fifo_count, 1);
        cmd_ready = 1'b1;
        tick();
        check("simul_drained", out_vec(), 0);

        // Overflow
        cmd_ready = 1'b0;
        key = 2'd1;
        for (int k = 0; k < 5; k++) begin
            press(ov_ch[k], 4'(k + 1));
            check($sformatf("ovf_count_%0d", k), fifo_count, ov_cnt[k]);
            check($sformatf("ovf_flag_%0d", k), overflow, ov_flag[k]);
        end
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_head_%0d", i), {cmd_valid, cmd_code, cmd_key, cmd_data},
                  {1'b1, 2'(dr_code[i]), 2'd1, 4'(i + 1)});
            tick();
        end
        check("drain_empty", cmd_valid, 0);
        check("drain_ovf_sticky", overflow, 1);
        cmd_ready = 1'b0;
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full FIFO: write coinciding with a pop
        press(0, 4'h6); press(1, 4'h7); press(2, 4'h8); press(0, 4'h9);
        check("refill_count", fifo_count, 4);
        data = 4'hB;
        btn[1] = 1'b0;
        repeat (6) tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("coinc_count", fifo_count, 4);
        check("coinc_ovf", overflow, 0);
        btn = 3'b111;
        repeat (8) tick();
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("coinc_head_%0d", i), {cmd_valid, cmd_code, cmd_data},
                  {1'b1, 2'(dr2_code[i]), 4'(dr2_data[i])});
            tick();
        end
        check("coinc_empty", out_vec(), 0);

        // Reset mid-debounce, with a command already queued
        cmd_ready = 1'b0;
        press(0, 4'h3);
        check("pre_reset_count", fifo_count, 1);
        btn = 3'b011;
        repeat (3) tick();
        async_nreset = 1'b0;
        #2 check("rst_mid_clear", out_vec(), 0);
        cmd_ready = 1'b1;
        @(posedge clk);
        #2 async_nreset = 1'b1;
        wait_valid(20, edges);
        check("rst_mid_latency", edges, D + 2);
        check("rst_mid_code", cmd_code, 3);
        tick();
        seen = 1'b0;
        repeat (10) begin tick(); seen |= cmd_valid; end
        check("rst_mid_single", seen, 0);
        btn = 3'b111;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
